seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode 7-segment display on the 100 MHz board clock. Accepts a 4-digit BCD value plus decimal-point mask over a valid/ready handshake. Sequences the digits with dead-time blanking between them. Commits new values only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DIGIT_CYCLES, 100000, clocks each digit is driven (1 ms at 100 MHz); legal range >= 2
BLANK_CYCLES, 1000, clocks of all-off dead time before each digit; legal range >= 1

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous reset, active-high
load_valid  input  1  new display value offered
load_ready  output  1  controller can accept a value
load_data  input  16  4 BCD digits; digit i = load_data[4i+3:4i], digit 0 = rightmost
load_dp  input  4  decimal point enable per digit, 1 = lit
an  output  [0:3]  anode enables, active-low; an[i] selects digit i
seg  output  [0:6]  segments active-low, order {G,F,E,D,C,B,A}
dp  output  1  decimal point, active-low

Behaviour:
- Reset (rst=1 at a clk edge):
  - State BLANK, digit index 0, phase counter 0.
  - Active digits = 0, active dp mask = 0, pending register empty.
  - Outputs: load_ready=1, an all 1, seg=7'h7F, dp=1.
  - Reset mid-frame or mid-handshake discards any pending value.
- FSM has two states:
  - BLANK: lasts BLANK_CYCLES clocks. an all 1, seg=7'h7F, dp=1.
  - DRIVE: lasts DIGIT_CYCLES clocks. an[idx]=0, all other an bits 1. seg = decode(active digit idx). dp = ~active_dp[idx].
- Transitions:
  - BLANK to DRIVE after BLANK_CYCLES clocks.
  - DRIVE to BLANK after DIGIT_CYCLES clocks; idx then increments modulo 4 (3 wraps to 0).
- Frame: 4*(BLANK_CYCLES+DIGIT_CYCLES) clocks. The frame boundary is the DRIVE-to-BLANK edge with idx=3.
- Output timing: an/seg/dp are registered and change on the same clk edge as the state/idx register. They never glitch, and no two an bits are ever low together.
- Decode (active-low, {G..A}):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex)
  - Codes A-F: 7'h7F (digit dark). dp is still driven per mask.
- Handshake:
  - Transfer occurs when load_valid && load_ready at a clk edge. load_data and load_dp are captured into the pending register.
  - load_ready drops to 0 on the next cycle and stays 0 while pending is full.
- Commit: at the frame boundary, if pending is full, copy pending to active. Pending becomes empty and load_ready returns to 1 on that same edge.
  - The first BLANK of the next frame uses the new value for all four digits.
- Simultaneous accept and frame boundary (ready=1 implies pending empty): the value is captured into pending and is not committed until the following frame boundary.
- load_valid held while ready=0 has no effect. load_data may change freely while not accepted.
- Counters:
  - Phase counter width is clog2(max(DIGIT_CYCLES, BLANK_CYCLES)).
  - Counter reloads to 0 on every state change; no free-running wrap.

Optional Feature:
SEG_LZ_BLANK_EN
- Defined: leading-zero suppression. Digits 3, 2, 1 are forced dark (seg=7'h7F, dp still per mask) while they and every more-significant digit equal 0. Digit 0 is never suppressed, so value 0000 shows a single "0". Evaluated on the active register at commit.
- Undefined: all four digits always decoded; 0000 shows four zeros.

Test Plan:
(params DIGIT_CYCLES=8, BLANK_CYCLES=2, frame = 40 clocks)
1. Reset sequencing: deassert rst, load_valid=0 -> 2 clocks all-off, then an[0]=0 only with seg=7'h40 for 8 clocks, then 2 off, then an[1]=0 for 8 clocks; idx returns to 0 after 40 clocks.
2. Load and commit: offer 16'h1234, dp=4'b0100 mid-frame -> load_ready=0 next clock; digits unchanged until the frame boundary. Next frame shows digit0 seg=7'h19, digit1 7'h30, digit2 7'h24 with dp=0, digit3 7'h79. load_ready=1 at the boundary.
3. Backpressure: hold load_valid=1 with 16'h5678 while ready=0 -> not captured. Captured on the first cycle ready=1; shown in the frame after the next boundary.
4. Accept on the boundary cycle: load 16'h9999 on the exact boundary edge -> old value is shown for one more full frame, then 9999 (seg=7'h10 on all digits).
5. Reset mid-DRIVE with pending full -> next cycle: an all 1, seg=7'h7F, load_ready=1; display shows 0000 (0 with SEG_LZ_BLANK_EN).
6. Invalid code and LZ: load 16'h00A7 -> digit1 dark (7'h7F). With SEG_LZ_BLANK_EN, digits 3 and 2 are also dark and digit0 shows 7'h78; without it, digits 3 and 2 show 7'h40.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller.
// Digits are driven one at a time, each preceded by an all-off dead time. New values arrive
// over a valid/ready handshake into a one-deep pending register and are committed to the
// displayed (active) register only at the frame boundary, so a frame never mixes values.
// Optional feature macro: SEG_LZ_BLANK_EN (leading-zero suppression on digits 3..1).
module seg_scan_ctrl #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic [0:3]  an,
    output logic [0:6]  seg,
    output logic        dp
);

    localparam int unsigned MaxCycles =
        (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_CYCLES - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [6:0]      SegOff    = 7'h7F;

    typedef enum logic [0:0] {StBlank, StDrive} state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     active_q, active_d;
    logic [3:0]      active_dp_q, active_dp_d;
    logic [15:0]     pend_q, pend_d;
    logic [3:0]      pend_dp_q, pend_dp_d;
    logic            pend_full_q, pend_full_d;
    logic [0:3]      an_q, an_d;
    logic [0:6]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_end;
    logic            accept;
    logic            commit;
    logic [3:0]      lz_mask;

    // Active-low {G,F,E,D,C,B,A}; non-BCD codes leave the digit dark.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SegOff;
        endcase
        return s;
    endfunction

    // Scan sequencer: phase counter reloads on every state change.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + CntOne;
        frame_end = 1'b0;
        unique case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StDrive;
                    cnt_d   = '0;
                end
            end
            StDrive: begin
                if (cnt_q == DigitLast) begin
                    state_d   = StBlank;
                    cnt_d     = '0;
                    idx_d     = idx_q + 2'd1;
                    frame_end = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = StBlank;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake and frame-boundary commit. Ready implies pending is empty, so an accept on
    // the boundary edge cannot commit at the same time; it waits for the next boundary.
    assign load_ready = ~pend_full_q;
    assign accept     = load_valid && load_ready;
    assign commit     = frame_end && pend_full_q;

    always_comb begin
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        if (accept) begin
            pend_d      = load_data;
            pend_dp_d   = load_dp;
            pend_full_d = 1'b1;
        end else if (commit) begin
            active_d    = pend_q;
            active_dp_d = pend_dp_q;
            pend_full_d = 1'b0;
        end
    end

    // Leading-zero mask derived from the value being committed; digit 0 always shows.
    always_comb begin
        lz_mask = 4'b0000;
`ifdef SEG_LZ_BLANK_EN
        lz_mask[3] = (active_d[15:12] == 4'd0);
        lz_mask[2] = lz_mask[3] && (active_d[11:8] == 4'd0);
        lz_mask[1] = lz_mask[2] && (active_d[7:4] == 4'd0);
`endif
    end

    // Outputs are built from next-state values so they register on the same edge as state.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SegOff;
        dp_d  = 1'b1;
        if (state_d == StDrive) begin
            an_d[idx_d] = 1'b0;
            seg_d       = lz_mask[idx_d] ? SegOff : decode(active_d[{idx_d, 2'b00} +: 4]);
            dp_d        = ~active_dp_d[idx_d];
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBlank;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            active_q    <= 16'h0000;
            active_dp_q <= 4'b0000;
            pend_q      <= 16'h0000;
            pend_dp_q   <= 4'b0000;
            pend_full_q <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= SegOff;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2 (40-clock frame).
// Stimulus pushes the expected digit windows of each frame; a negedge monitor pops one per
// observed drive window and also checks window/blank lengths and output stability.
module tb_seg_scan_ctrl;

    localparam int unsigned DIGIT = 8;
    localparam int unsigned BLANK = 2;
`ifdef SEG_LZ_BLANK_EN
    localparam logic [6:0] ZL = 7'h7F;
`else
    localparam logic [6:0] ZL = 7'h40;
`endif

    typedef struct {
        logic [0:3] an;
        logic [6:0] seg;
        logic       dp;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  load_dp = 4'b0000;
    logic [0:3]  an;
    logic [0:6]  seg;
    logic        dp;

    item_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;

    seg_scan_ctrl #(
        .DIGIT_CYCLES(DIGIT),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .load_dp   (load_dp),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected segments for digits 0..3 and the decimal-point mask of one frame.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] m);
        logic [6:0] s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            item_t it;
            it.an    = 4'b1111;
            it.an[i] = 1'b0;
            it.seg   = s[i];
            it.dp    = ~m[i];
            exp_q.push_back(it);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Monitor state.
    bit         in_win = 1'b0;
    int         run_len = 0;
    bit         stable = 1'b1;
    bit         blank_ok = 1'b1;
    logic [0:3] w_an;
    logic [6:0] w_seg;
    logic       w_dp;

    task automatic start_window();
        item_t it;
        check("blank_len", run_len, BLANK);
        check("blank_dark", {31'd0, blank_ok}, 32'd1);
        if (exp_q.size() == 0) begin
            check("unexpected_window", {28'd0, an}, 32'hF);
        end else begin
            it = exp_q.pop_front();
            check("win_an", {28'd0, an}, {28'd0, it.an});
            check("win_seg", {25'd0, seg}, {25'd0, it.seg});
            check("win_dp", {31'd0, dp}, {31'd0, it.dp});
        end
        w_an = an; w_seg = seg; w_dp = dp;
        stable = 1'b1;
        run_len = 1;
        in_win = 1'b1;
    endtask

    task automatic end_window();
        check("win_len", run_len, DIGIT);
        check("win_stable", {31'd0, stable}, 32'd1);
        in_win = 1'b0;
        run_len = 0;
        blank_ok = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_win = 1'b0;
            run_len = 0;
            blank_ok = 1'b1;
        end else begin
            if (in_win && an != w_an) end_window();
            if (!in_win) begin
                if (an == 4'b1111) begin
                    run_len++;
                    if (seg != 7'h7F || dp != 1'b1) blank_ok = 1'b0;
                end else begin
                    start_window();
                end
            end else begin
                run_len++;
                if (seg != w_seg || dp != w_dp) stable = 1'b0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_ready", {31'd0, load_ready}, 32'd1);
        rst = 1'b0;
        cyc = 0;
        // Frame 0: reset value 0000.
        push_frame(7'h40, ZL, ZL, ZL, 4'b0000);

        // Load mid-frame; held until the boundary.
        goto(10);
        load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'b0100;
        goto(11);
        load_valid = 1'b0;
        check("ready_after_load", {31'd0, load_ready}, 32'd0);
        goto(39);
        check("ready_before_boundary", {31'd0, load_ready}, 32'd0);
        goto(40);
        check("ready_at_boundary", {31'd0, load_ready}, 32'd1);
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0100);

        // Backpressure: 5678 held while pending is full.
        goto(45);
        load_valid = 1'b1; load_data = 16'h2468; load_dp = 4'b0000;
        goto(46);
        load_valid = 1'b0;
        check("ready_2468", {31'd0, load_ready}, 32'd0);
        goto(50);
        load_valid = 1'b1; load_data = 16'h5678; load_dp = 4'b1000;
        goto(79);
        check("ready_held_low", {31'd0, load_ready}, 32'd0);
        goto(80);
        check("ready_frame2", {31'd0, load_ready}, 32'd1);
        push_frame(7'h00, 7'h02, 7'h19, 7'h24, 4'b0000);
        goto(81);
        load_valid = 1'b0;
        check("ready_5678_taken", {31'd0, load_ready}, 32'd0);
        goto(120);
        check("ready_frame3", {31'd0, load_ready}, 32'd1);
        push_frame(7'h00, 7'h78, 7'h02, 7'h12, 4'b1000);

        // Accept exactly on the boundary edge: old value stays one more frame.
        goto(159);
        load_valid = 1'b1; load_data = 16'h9999; load_dp = 4'b0001;
        goto(160);
        load_valid = 1'b0;
        check("ready_boundary_accept", {31'd0, load_ready}, 32'd0);
        push_frame(7'h00, 7'h78, 7'h02, 7'h12, 4'b1000);
        goto(200);
        check("ready_frame5", {31'd0, load_ready}, 32'd1);
        push_frame(7'h10, 7'h10, 7'h10, 7'h10, 4'b0001);

        // Reset mid-DRIVE with a pending value.
        goto(205);
        load_valid = 1'b1; load_data = 16'h4321; load_dp = 4'b1111;
        goto(206);
        load_valid = 1'b0;
        check("ready_4321", {31'd0, load_ready}, 32'd0);
        goto(215);
        rst = 1'b1;
        exp_q.delete();
        goto(216);
        check("midrst_an", {28'd0, an}, 32'hF);
        check("midrst_seg", {25'd0, seg}, 32'h7F);
        check("midrst_dp", {31'd0, dp}, 32'd1);
        check("midrst_ready", {31'd0, load_ready}, 32'd1);
        rst = 1'b0;
        cyc = 0;
        push_frame(7'h40, ZL, ZL, ZL, 4'b0000);

        // Invalid code and leading zeros.
        goto(5);
        load_valid = 1'b1; load_data = 16'h00A7; load_dp = 4'b0010;
        goto(6);
        load_valid = 1'b0;
        check("ready_00a7", {31'd0, load_ready}, 32'd0);
        goto(40);
        check("ready_00a7_commit", {31'd0, load_ready}, 32'd1);
        push_frame(7'h78, 7'h7F, ZL, ZL, 4'b0010);

        goto(81);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
